// File: rtl/k_means_controller.sv
// -----------------------------------------------------------------------------
// k_means_controller
//
// Iteration controller for the three-centroid k_means clusterer. It holds the
// current centroids, which feed k_means for a whole frame. At every frame end
// it pulses tabulate and waits for the divided centroids to come back. Each
// returned centroid that is out of range is rejected, which also covers the
// empty-cluster divide result. It then measures how far each centroid moved
// and publishes the result.
//
// Optional build macro: CENTROID_SORT_EN
//   When defined, the accepted centroids are reordered by ascending x before
//   they are published and fed back. This adds one cycle to the update latency.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-high reset
//   frame_end_in          last pixel of the frame accumulated (pulse)
//   tabulate_out          request to k_means to divide its sums (pulse)
//   km_valid_in           k_means quotients valid (pulse)
//   km_{a,b,c}_{x,y}_in   k_means quotients (x 11 bit, y 10 bit)
//   cent_{a,b,c}_{x,y}_out current centroids, fed back to k_means
//   cent_valid_out        centroids updated this cycle (pulse)
//   converged_out         every centroid moved <= CONV_THRESH last iteration
//   timeout_out           sticky: k_means failed to answer a tabulate
//   iter_count_out        completed iterations, saturating
// -----------------------------------------------------------------------------
module k_means_controller #(
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int TIMEOUT     = 256,
    parameter int CONV_THRESH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_end_in,
    output logic        tabulate_out,
    input  logic        km_valid_in,
    input  logic [10:0] km_a_x_in,
    input  logic [9:0]  km_a_y_in,
    input  logic [10:0] km_b_x_in,
    input  logic [9:0]  km_b_y_in,
    input  logic [10:0] km_c_x_in,
    input  logic [9:0]  km_c_y_in,
    output logic [10:0] cent_a_x_out,
    output logic [9:0]  cent_a_y_out,
    output logic [10:0] cent_b_x_out,
    output logic [9:0]  cent_b_y_out,
    output logic [10:0] cent_c_x_out,
    output logic [9:0]  cent_c_y_out,
    output logic        cent_valid_out,
    output logic        converged_out,
    output logic        timeout_out,
    output logic [15:0] iter_count_out
);

    localparam int                TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [10:0]       H_LIM    = 11'(H_ACTIVE);
    localparam logic [9:0]        V_LIM    = 10'(V_ACTIVE);
    localparam logic [10:0]       SEED_AX  = 11'(H_ACTIVE / 6);
    localparam logic [10:0]       SEED_BX  = 11'(H_ACTIVE / 2);
    localparam logic [10:0]       SEED_CX  = 11'((5 * H_ACTIVE) / 6);
    localparam logic [9:0]        SEED_Y   = 10'(V_ACTIVE / 2);
    localparam logic [11:0]       THRESH   = 12'(CONV_THRESH);

    typedef enum logic [2:0] {
        S_IDLE, S_TAB, S_WAIT, S_UPDATE, S_SORT, S_PUBLISH
    } state_t;

    // |dx| + |dy| between a new and an old centroid.
    function automatic logic [11:0] manhattan(input logic [10:0] nx, input logic [10:0] ox,
                                              input logic [9:0]  ny, input logic [9:0]  oy);
        logic signed [11:0] dx;
        logic signed [10:0] dy;
        logic [11:0]        adx;
        logic [11:0]        ady;
        dx  = $signed({1'b0, nx}) - $signed({1'b0, ox});
        dy  = $signed({1'b0, ny}) - $signed({1'b0, oy});
        adx = dx[11] ? 12'(-dx) : 12'(dx);
        ady = dy[10] ? 12'(-dy) : 12'(dy);
        return adx + ady;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t            r_state, w_next;
    logic [TMR_W-1:0]  r_timer;
    logic              w_tab, w_cvalid, w_timeout_hit;
    logic [10:0]       r_km_ax, r_km_bx, r_km_cx;
    logic [9:0]        r_km_ay, r_km_by, r_km_cy;
    logic [10:0]       r_cent_ax, r_cent_bx, r_cent_cx;
    logic [9:0]        r_cent_ay, r_cent_by, r_cent_cy;
    logic              r_conv, r_timeout;
    logic [15:0]       r_iter;
    logic              w_ok_a, w_ok_b, w_ok_c;
    logic [10:0]       w_sel_ax, w_sel_bx, w_sel_cx;
    logic [9:0]        w_sel_ay, w_sel_by, w_sel_cy;
    logic [11:0]       w_mv_a, w_mv_b, w_mv_c;
    logic              w_conv;

    // Rejection: an out-of-range quotient keeps the old centroid and counts as no move.
    assign w_ok_a   = (r_km_ax < H_LIM) && (r_km_ay < V_LIM);
    assign w_ok_b   = (r_km_bx < H_LIM) && (r_km_by < V_LIM);
    assign w_ok_c   = (r_km_cx < H_LIM) && (r_km_cy < V_LIM);
    assign w_sel_ax = w_ok_a ? r_km_ax : r_cent_ax;
    assign w_sel_ay = w_ok_a ? r_km_ay : r_cent_ay;
    assign w_sel_bx = w_ok_b ? r_km_bx : r_cent_bx;
    assign w_sel_by = w_ok_b ? r_km_by : r_cent_by;
    assign w_sel_cx = w_ok_c ? r_km_cx : r_cent_cx;
    assign w_sel_cy = w_ok_c ? r_km_cy : r_cent_cy;
    assign w_mv_a   = w_ok_a ? manhattan(r_km_ax, r_cent_ax, r_km_ay, r_cent_ay) : 12'd0;
    assign w_mv_b   = w_ok_b ? manhattan(r_km_bx, r_cent_bx, r_km_by, r_cent_by) : 12'd0;
    assign w_mv_c   = w_ok_c ? manhattan(r_km_cx, r_cent_cx, r_km_cy, r_cent_cy) : 12'd0;
    assign w_conv   = (w_mv_a <= THRESH) && (w_mv_b <= THRESH) && (w_mv_c <= THRESH);

`ifdef CENTROID_SORT_EN
    // Accepted centroids packed as {x, y}, held for the sort cycle.
    logic [20:0] r_sel0, r_sel1, r_sel2;
    logic        r_conv_pend;
    logic [20:0] w_srt0, w_srt1, w_srt2, w_tmp;

    // Three-element bubble sort on x; strict compares keep tied slots in order.
    always_comb begin
        w_srt0 = r_sel0;
        w_srt1 = r_sel1;
        w_srt2 = r_sel2;
        w_tmp  = '0;
        if (w_srt0[20:10] > w_srt1[20:10]) begin
            w_tmp = w_srt0; w_srt0 = w_srt1; w_srt1 = w_tmp;
        end
        if (w_srt1[20:10] > w_srt2[20:10]) begin
            w_tmp = w_srt1; w_srt1 = w_srt2; w_srt2 = w_tmp;
        end
        if (w_srt0[20:10] > w_srt1[20:10]) begin
            w_tmp = w_srt0; w_srt0 = w_srt1; w_srt1 = w_tmp;
        end
    end
`endif

    always_comb begin
        w_next        = r_state;
        w_tab         = 1'b0;
        w_cvalid      = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE:    if (frame_end_in) w_next = S_TAB;
            S_TAB: begin
                w_tab  = 1'b1;
                w_next = S_WAIT;
            end
            // A valid arriving on the last timer cycle takes priority over the abort.
            S_WAIT: begin
                if (km_valid_in) begin
                    w_next = S_UPDATE;
                end else if (r_timer == TMR_LAST) begin
                    w_next        = S_IDLE;
                    w_timeout_hit = 1'b1;
                end
            end
`ifdef CENTROID_SORT_EN
            S_UPDATE:  w_next = S_SORT;
`else
            S_UPDATE:  w_next = S_PUBLISH;
`endif
            S_SORT:    w_next = S_PUBLISH;
            S_PUBLISH: begin
                w_cvalid = 1'b1;
                w_next   = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_cent_ax <= SEED_AX;
            r_cent_ay <= SEED_Y;
            r_cent_bx <= SEED_BX;
            r_cent_by <= SEED_Y;
            r_cent_cx <= SEED_CX;
            r_cent_cy <= SEED_Y;
            r_conv    <= 1'b0;
            r_timeout <= 1'b0;
            r_iter    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_TAB) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer + TMR_W'(1);
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
            // Centroids, flag and count are committed together on the edge into PUBLISH.
`ifdef CENTROID_SORT_EN
            if (r_state == S_SORT) begin
                {r_cent_ax, r_cent_ay} <= w_srt0;
                {r_cent_bx, r_cent_by} <= w_srt1;
                {r_cent_cx, r_cent_cy} <= w_srt2;
                r_conv                 <= r_conv_pend;
                r_iter                 <= sat_inc16(r_iter);
            end
`else
            if (r_state == S_UPDATE) begin
                r_cent_ax <= w_sel_ax;
                r_cent_ay <= w_sel_ay;
                r_cent_bx <= w_sel_bx;
                r_cent_by <= w_sel_by;
                r_cent_cx <= w_sel_cx;
                r_cent_cy <= w_sel_cy;
                r_conv    <= w_conv;
                r_iter    <= sat_inc16(r_iter);
            end
`endif
        end
    end

    // Data-only registers: no reset needed, always written before use.
    always_ff @(posedge clk_in) begin
        if ((r_state == S_WAIT) && km_valid_in) begin
            r_km_ax <= km_a_x_in;
            r_km_ay <= km_a_y_in;
            r_km_bx <= km_b_x_in;
            r_km_by <= km_b_y_in;
            r_km_cx <= km_c_x_in;
            r_km_cy <= km_c_y_in;
        end
`ifdef CENTROID_SORT_EN
        if (r_state == S_UPDATE) begin
            r_sel0      <= {w_sel_ax, w_sel_ay};
            r_sel1      <= {w_sel_bx, w_sel_by};
            r_sel2      <= {w_sel_cx, w_sel_cy};
            r_conv_pend <= w_conv;
        end
`endif
    end

    assign tabulate_out   = w_tab;
    assign cent_valid_out = w_cvalid;
    assign cent_a_x_out   = r_cent_ax;
    assign cent_a_y_out   = r_cent_ay;
    assign cent_b_x_out   = r_cent_bx;
    assign cent_b_y_out   = r_cent_by;
    assign cent_c_x_out   = r_cent_cx;
    assign cent_c_y_out   = r_cent_cy;
    assign converged_out  = r_conv;
    assign timeout_out    = r_timeout;
    assign iter_count_out = r_iter;

endmodule

// File: tb/tb_k_means_controller.sv
// -----------------------------------------------------------------------------
// tb_k_means_controller
//
// Directed bench for k_means_controller. Inputs are driven and outputs sampled
// on the falling clock edge. Expected centroids, move flags and counts are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_k_means_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        fe;
    logic        tabulate_out;
    logic        km_valid;
    logic [10:0] kax, kbx, kcx;
    logic [9:0]  kay, kby, kcy;
    logic [10:0] cax, cbx, ccx;
    logic [9:0]  cay, cby, ccy;
    logic        cent_valid_out, converged_out, timeout_out;
    logic [15:0] iter_count_out;

    logic [10:0] s_ax, s_bx, s_cx;
    logic [9:0]  s_ay, s_by, s_cy;

    int n_checks = 0;
    int n_errors = 0;

`ifdef CENTROID_SORT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    always #5 clk = ~clk;

    k_means_controller dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .frame_end_in   (fe),
        .tabulate_out   (tabulate_out),
        .km_valid_in    (km_valid),
        .km_a_x_in      (kax),
        .km_a_y_in      (kay),
        .km_b_x_in      (kbx),
        .km_b_y_in      (kby),
        .km_c_x_in      (kcx),
        .km_c_y_in      (kcy),
        .cent_a_x_out   (cax),
        .cent_a_y_out   (cay),
        .cent_b_x_out   (cbx),
        .cent_b_y_out   (cby),
        .cent_c_x_out   (ccx),
        .cent_c_y_out   (ccy),
        .cent_valid_out (cent_valid_out),
        .converged_out  (converged_out),
        .timeout_out    (timeout_out),
        .iter_count_out (iter_count_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_km(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy);
        kax = 11'(ax); kay = 10'(ay);
        kbx = 11'(bx); kby = 10'(by);
        kcx = 11'(cx); kcy = 10'(cy);
    endtask

    task automatic chk_live(input string tag, input int ax, input int ay, input int bx,
                            input int by, input int cx, input int cy);
        chk({tag, "_ax"}, cax, ax); chk({tag, "_ay"}, cay, ay);
        chk({tag, "_bx"}, cbx, bx); chk({tag, "_by"}, cby, by);
        chk({tag, "_cx"}, ccx, cx); chk({tag, "_cy"}, ccy, cy);
    endtask

    task automatic chk_snap(input string tag, input int ax, input int ay, input int bx,
                            input int by, input int cx, input int cy);
        chk({tag, "_ax"}, s_ax, ax); chk({tag, "_ay"}, s_ay, ay);
        chk({tag, "_bx"}, s_bx, bx); chk({tag, "_by"}, s_by, by);
        chk({tag, "_cx"}, s_cx, cx); chk({tag, "_cy"}, s_cy, cy);
    endtask

    // Frame end, then km_valid sampled in WAIT cycle number d (0 = first).
    // Optionally pulses frame_end during WAIT, which must not re-tabulate.
    task automatic run_iter(input int d, input bit fe_mid);
        int tabs;
        tabs = 0;
        fe = 1'b1;
        @(negedge clk);
        fe = 1'b0;
        chk("tab_pulse", tabulate_out, 1);
        @(negedge clk);
        chk("tab_low", tabulate_out, 0);
        for (int i = 0; i < d; i++) begin
            fe = fe_mid && (i == 10);
            @(negedge clk);
            if (tabulate_out) tabs++;
        end
        fe = 1'b0;
        if (fe_mid) chk("tab_extra", tabs, 0);
        km_valid = 1'b1;
        @(negedge clk);
        km_valid = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            chk("cv_early", cent_valid_out, 0);
            @(negedge clk);
        end
        chk("cv_pulse", cent_valid_out, 1);
        s_ax = cax; s_ay = cay; s_bx = cbx; s_by = cby; s_cx = ccx; s_cy = ccy;
        @(negedge clk);
        chk("cv_drop", cent_valid_out, 0);
    endtask

    initial begin
        int cvs;
        rst = 1'b1; fe = 1'b0; km_valid = 1'b0;
        set_km(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk_live("rst", 213, 360, 640, 360, 1066, 360);
        chk("rst_tab", tabulate_out, 0);
        chk("rst_cv", cent_valid_out, 0);
        chk("rst_conv", converged_out, 0);
        chk("rst_to", timeout_out, 0);
        chk("rst_iter", iter_count_out, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_tab", tabulate_out, 0);

        // First iteration: a moves 13+10=23, not converged.
        set_km(200, 350, 640, 362, 1070, 360);
        run_iter(38, 1'b1);
        chk_snap("it1", 200, 350, 640, 362, 1070, 360);
        chk("it1_conv", converged_out, 0);
        chk("it1_iter", iter_count_out, 1);

        // Same quotients: zero movement.
        run_iter(38, 1'b0);
        chk_snap("it2", 200, 350, 640, 362, 1070, 360);
        chk("it2_conv", converged_out, 1);
        chk("it2_iter", iter_count_out, 2);

        // Empty cluster c rejected; a moves 5 -> not converged.
        set_km(205, 350, 641, 362, 2047, 1023);
        run_iter(5, 1'b0);
        chk_snap("it3", 205, 350, 641, 362, 1070, 360);
        chk("it3_conv", converged_out, 0);
        chk("it3_iter", iter_count_out, 3);

        // x == H_ACTIVE rejected; a moves exactly the threshold.
        set_km(209, 350, 641, 362, 1280, 100);
        run_iter(5, 1'b0);
        chk_snap("it4", 209, 350, 641, 362, 1070, 360);
        chk("it4_conv", converged_out, 1);
        chk("it4_iter", iter_count_out, 4);

        // y == V_ACTIVE rejected for b; c at the last valid pixel accepted.
        set_km(209, 350, 641, 720, 1279, 719);
        run_iter(5, 1'b0);
        chk_snap("it5", 209, 350, 641, 362, 1279, 719);
        chk("it5_conv", converged_out, 0);
        chk("it5_iter", iter_count_out, 5);

        // Valid on the final timer cycle wins over the timeout.
        set_km(210, 350, 641, 362, 1279, 719);
        run_iter(255, 1'b0);
        chk_snap("edge", 210, 350, 641, 362, 1279, 719);
        chk("edge_to", timeout_out, 0);
        chk("edge_conv", converged_out, 1);
        chk("edge_iter", iter_count_out, 6);

        // No answer from k_means: abort after 256 WAIT cycles.
        cvs = 0;
        fe = 1'b1;
        @(negedge clk);
        fe = 1'b0;
        chk("to_tab", tabulate_out, 1);
        @(negedge clk);
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (cent_valid_out) cvs++;
        end
        chk("to_before", timeout_out, 0);
        @(negedge clk);
        chk("to_set", timeout_out, 1);
        // km_valid in IDLE is ignored.
        set_km(1, 1, 1, 1, 1, 1);
        km_valid = 1'b1;
        @(negedge clk);
        km_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cent_valid_out) cvs++;
            @(negedge clk);
        end
        chk("to_no_cv", cvs, 0);
        chk_live("to_hold", 210, 350, 641, 362, 1279, 719);
        chk("to_iter", iter_count_out, 6);

        // Later frame re-tabulates normally; timeout stays sticky.
        set_km(300, 400, 641, 362, 1279, 719);
        run_iter(20, 1'b0);
        chk_snap("re", 300, 400, 641, 362, 1279, 719);
        chk("re_to", timeout_out, 1);
        chk("re_conv", converged_out, 0);
        chk("re_iter", iter_count_out, 7);

`ifdef CENTROID_SORT_EN
        set_km(900, 100, 100, 200, 500, 300);
        run_iter(10, 1'b1);
        chk_snap("sort", 100, 200, 500, 300, 900, 100);
        chk("sort_iter", iter_count_out, 8);
`endif

        // Reset in the middle of WAIT.
        fe = 1'b1;
        @(negedge clk);
        fe = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_live("mrst", 213, 360, 640, 360, 1066, 360);
        chk("mrst_to", timeout_out, 0);
        chk("mrst_conv", converged_out, 0);
        chk("mrst_iter", iter_count_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_tab", tabulate_out, 0);
        set_km(213, 360, 640, 360, 1066, 360);
        run_iter(3, 1'b0);
        chk_snap("post", 213, 360, 640, 360, 1066, 360);
        chk("post_conv", converged_out, 1);
        chk("post_iter", iter_count_out, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
